// File: rtl/selector_encoder_pkg.sv
// Shared sizing constants and FSM state encoding for the selector encoder.
package selector_encoder_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/selector_encoder_rr_pick.sv
// Priority search over req: first set bit found walking upward from ptr, wrapping at the top.
module rr_pick
    import selector_encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // rot[0] is the request sitting at ptr, so the lowest set bit of rot is the winner
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [SEL_W-1:0] src;
            assign src     = ptr + SEL_W'(gi);
            assign rot[gi] = req[src];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + off;

endmodule

// File: rtl/selector_encoder.sv
// Request-to-selector encoder with a valid/ready handshake toward the consumer and an ack back to requesters.
// Optional macro SELECTOR_ENCODER_RR_EN switches fixed lowest-index priority to round-robin arbitration.
module selector_encoder #(
    parameter int N_REQ = selector_encoder_pkg::N_REQ,
    parameter int SEL_W = selector_encoder_pkg::SEL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic             busy,
    output logic [7:0]       grant_count
);

    import selector_encoder_pkg::*;

    state_t           state_reg;
    state_t           state_next;
    logic [SEL_W-1:0] sel_reg;
    logic [N_REQ-1:0] ack_reg;
    logic [N_REQ-1:0] ack_next;
    logic [7:0]       grant_count_reg;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic [SEL_W-1:0] search_ptr;
    logic             capture;
    logic             handshake;

`ifdef SELECTOR_ENCODER_RR_EN
    logic [SEL_W-1:0] ptr_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (handshake) begin
            ptr_reg <= sel_reg + SEL_W'(1);
        end
    end

    assign search_ptr = ptr_reg;
`else
    assign search_ptr = '0;
`endif

    rr_pick u_pick (
        .req (req),
        .ptr (search_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign capture   = (state_reg == IDLE) && pick_any;
    assign handshake = (state_reg == HOLD) && sel_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_any)  state_next = HOLD;
            HOLD:    if (sel_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_valid = 1'b0;
        busy      = 1'b0;
        if (state_reg == HOLD) begin
            sel_valid = 1'b1;
            busy      = 1'b1;
        end
    end

    // Ack is decoded from the held code, so the pulse lands in the cycle after the handshake edge
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack_next[gi] = handshake && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_reg         <= '0;
            ack_reg         <= '0;
            grant_count_reg <= '0;
        end else begin
            ack_reg <= ack_next;
            if (capture) begin
                sel_reg <= pick_idx;
            end
            if (handshake) begin
                grant_count_reg <= grant_count_reg + 8'd1;
            end
        end
    end

    assign sel         = sel_reg;
    assign ack         = ack_reg;
    assign grant_count = grant_count_reg;

endmodule
